// File: rtl/seq_detector_pkg.sv
// Shared types and bounds for the serial pattern detector.
// Holds the fill-state enum and the legal range of the pattern length.
package seq_detector_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_e;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    // count register: reset, clear, saturating increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {CNT_W{1'b0}};
        end else if (clr) begin
            r_count <= {CNT_W{1'b0}};
        end else if (inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector with fill-tracking FSM and one-cycle match pulse.
// Define SEQ_DETECTOR_COUNT_EN to build the saturating match counter.
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b0101,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             A_valid,
    input  logic             clr_cnt,
    output logic             Y,
    output logic             armed,
    output logic [CNT_W-1:0] match_count
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
        $error("seq_detector: PAT_W out of range");
    end

    logic [PAT_W-1:0]  r_window;
    logic [FILL_W-1:0] r_fill;
    state_e            r_state;
    logic              r_y;
    logic              r_armed;

    logic [PAT_W-1:0]  w_window_shift;
    logic [PAT_W-1:0]  w_window_nxt;
    logic [FILL_W-1:0] w_fill_inc;
    logic [FILL_W-1:0] w_fill_nxt;
    state_e            w_state_nxt;
    logic              w_match;

    // next window, fill, match and state; the state is a pure function of fill
    always_comb begin
        w_window_shift = {r_window[PAT_W-2:0], A};
        w_fill_inc     = (r_fill == FILL_FULL) ? r_fill : (r_fill + FILL_W'(1));
        w_match        = 1'b0;
        w_window_nxt   = r_window;
        w_fill_nxt     = r_fill;
        if (A_valid) begin
            w_match      = (w_window_shift == PATTERN) && (w_fill_inc == FILL_FULL);
            w_window_nxt = w_window_shift;
            if (w_match && (OVERLAP == 0)) begin
                w_fill_nxt = {FILL_W{1'b0}};
            end else begin
                w_fill_nxt = w_fill_inc;
            end
        end else begin
            w_match = 1'b0;
        end
        if (w_fill_nxt == {FILL_W{1'b0}}) begin
            w_state_nxt = EMPTY;
        end else if (w_fill_nxt == FILL_FULL) begin
            w_state_nxt = ARMED;
        end else begin
            w_state_nxt = FILLING;
        end
    end

    // state, window, fill and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_window <= {PAT_W{1'b0}};
            r_fill   <= {FILL_W{1'b0}};
            r_state  <= EMPTY;
            r_y      <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_window <= w_window_nxt;
            r_fill   <= w_fill_nxt;
            r_state  <= w_state_nxt;
            r_y      <= w_match;
            r_armed  <= (w_state_nxt == ARMED);
        end
    end

    assign Y     = r_y;
    assign armed = r_armed;

`ifdef SEQ_DETECTOR_COUNT_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_match),
        .clr   (clr_cnt),
        .count (match_count)
    );
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_cnt;
    assign match_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench: three detector builds (overlap, no-overlap, 2-bit counter) on shared stimulus.
module tb_seq_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       A = 1'b0;
    logic       A_valid = 1'b0;
    logic       clr_cnt = 1'b0;

    logic       y_ov, y_nov, y_c2;
    logic       armed_ov, armed_nov, armed_c2;
    logic [7:0] cnt_ov, cnt_nov;
    logic [1:0] cnt_c2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_detector #(.OVERLAP(1)) u_ov (
        .clk(clk), .rst(rst), .A(A), .A_valid(A_valid), .clr_cnt(clr_cnt),
        .Y(y_ov), .armed(armed_ov), .match_count(cnt_ov));

    seq_detector #(.OVERLAP(0)) u_nov (
        .clk(clk), .rst(rst), .A(A), .A_valid(A_valid), .clr_cnt(clr_cnt),
        .Y(y_nov), .armed(armed_nov), .match_count(cnt_nov));

    seq_detector #(.OVERLAP(1), .CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .A(A), .A_valid(A_valid), .clr_cnt(clr_cnt),
        .Y(y_c2), .armed(armed_c2), .match_count(cnt_c2));

    typedef struct {
        logic y[3];
        logic armed[3];
        int   cnt[3];
    } exp_t;

    exp_t exp_q[$];

    // reference state per instance
    logic [3:0] m_win[3];
    int         m_fill[3];
    int         m_cnt[3];
    int         m_ov[3]  = '{1, 0, 1};
    int         m_max[3] = '{255, 255, 3};

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s obs=%0d exp=%0d at t=%0t", tag, obs, expv, $time);
        end
    endtask

    // drive one cycle, push model expectation, then compare after the edge
    task automatic step(input logic r, input logic v, input logic a, input logic c);
        exp_t e;
        logic m;
        rst = r; A_valid = v; A = a; clr_cnt = c;
        for (int i = 0; i < 3; i++) begin
            m = 1'b0;
            if (r) begin
                m_win[i] = 4'b0000; m_fill[i] = 0; m_cnt[i] = 0;
            end else begin
                if (v) begin
                    m_win[i]  = {m_win[i][2:0], a};
                    m_fill[i] = (m_fill[i] < 4) ? m_fill[i] + 1 : 4;
                    m = (m_win[i] == 4'b0101) && (m_fill[i] == 4);
                    if (m && (m_ov[i] == 0)) m_fill[i] = 0;
                end
                if (c) m_cnt[i] = 0;
                else if (m && (m_cnt[i] < m_max[i])) m_cnt[i] = m_cnt[i] + 1;
            end
            e.y[i]     = m;
            e.armed[i] = (m_fill[i] == 4);
`ifdef SEQ_DETECTOR_COUNT_EN
            e.cnt[i]   = m_cnt[i];
`else
            e.cnt[i]   = 0;
`endif
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("ov_y",      int'(y_ov),      int'(e.y[0]));
            chk("ov_armed",  int'(armed_ov),  int'(e.armed[0]));
            chk("ov_cnt",    int'(cnt_ov),    e.cnt[0]);
            chk("nov_y",     int'(y_nov),     int'(e.y[1]));
            chk("nov_armed", int'(armed_nov), int'(e.armed[1]));
            chk("nov_cnt",   int'(cnt_nov),   e.cnt[1]);
            chk("c2_y",      int'(y_c2),      int'(e.y[2]));
            chk("c2_armed",  int'(armed_c2),  int'(e.armed[2]));
            chk("c2_cnt",    int'(cnt_c2),    e.cnt[2]);
        end
    endtask

    task automatic bits(input logic [15:0] pat, input int n);
        for (int k = n - 1; k >= 0; k--) step(1'b0, 1'b1, pat[k], 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_win[i] = 4'b0000; m_fill[i] = 0; m_cnt[i] = 0;
        end
        // reset then 0,1,0,1 and an overlapping 0,1
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        bits(16'b010101, 6);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // invalid cycles with A toggling are ignored
        step(1'b1, 1'b0, 1'b0, 1'b0);
        bits(16'b01, 2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        bits(16'b01, 2);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // five overlapping matches, clear on the fifth
        step(1'b1, 1'b0, 1'b0, 1'b0);
        bits(16'b0101, 4);
        bits(16'b010101, 6);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // reset mid-sequence discards the partial pattern
        step(1'b1, 1'b0, 1'b0, 1'b0);
        bits(16'b010, 3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        bits(16'b1, 1);
        bits(16'b010, 3);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // clear and match together, and reset overriding valid/clear
        bits(16'b0101, 4);
        step(1'b1, 1'b1, 1'b1, 1'b1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end

        if (exp_q.size() != 0) chk("queue_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b0101, PAT_W bits wide: target sequence; the MSB is the oldest bit received.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches are allowed; 0 = the detector restarts after each match.
REQ-004 Parameter CNT_W, default 8: width of the match counter.
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 A  input  1  serial data bit.
REQ-008 A_valid  input  1  A is sampled only on cycles where A_valid=1.
REQ-009 clr_cnt  input  1  synchronous clear of match_count.
REQ-010 Y  output  1  registered one-cycle match pulse.
REQ-011 armed  output  1  high when at least PAT_W valid bits are held in the window.
REQ-012 match_count  output  CNT_W  saturating count of matches.

Function
REQ-013 On each cycle with A_valid=1, the window shift register shall shift left by one and insert A at the LSB.
REQ-014 On each cycle with A_valid=0, the window, fill count, state and counter shall hold; Y shall be 0 on the next cycle.
REQ-015 A fill counter, width $clog2(PAT_W+1), shall increment per valid bit and saturate at PAT_W.
REQ-016 FSM states:
  - EMPTY: fill=0.
  - FILLING: 0<fill<PAT_W.
  - ARMED: fill=PAT_W.
  - The state shall follow fill exactly; armed=1 only in ARMED.
REQ-017 A match occurs when the post-shift window equals PATTERN and the post-shift fill equals PAT_W.
REQ-018 Y shall assert on the cycle after the matching valid bit is sampled (latency 1) and stay high for exactly one cycle per match.
REQ-019 OVERLAP=1: after a match, the window and fill shall be retained, so the trailing bits count toward the next match.
REQ-020 OVERLAP=0: on a match, fill shall be cleared to 0 and the state shall return to EMPTY; the next match needs PAT_W fresh valid bits.
REQ-021 Each match shall increment match_count by 1, saturating at 2^CNT_W-1 (no wrap-around).
REQ-022 When clr_cnt=1, match_count shall become 0 on the next edge.
REQ-023 When clr_cnt and a match occur in the same cycle, the clear shall win (count=0); Y shall still pulse.
REQ-024 clr_cnt shall not affect the window, fill, state or Y.
REQ-025 Y, armed and match_count shall be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-026 On any edge with rst=1:
  - window = 0, fill = 0, state = EMPTY;
  - Y = 0, armed = 0, match_count = 0.
REQ-027 rst shall override A_valid and clr_cnt.
REQ-028 A reset asserted in mid-sequence shall discard any partial pattern; no Y pulse shall follow reset release until PAT_W new valid bits have been received.

Configuration
REQ-029 With macro SEQ_DETECTOR_COUNT_EN defined, the match counter and clr_cnt shall function as specified.
REQ-030 Without SEQ_DETECTOR_COUNT_EN:
  - no counter flops shall be built;
  - match_count shall be tied to 0;
  - clr_cnt shall be ignored;
  - all other behaviour shall be unchanged.

Structure
REQ-031 A shared package seq_detector_pkg shall hold the state enum typedef (EMPTY, FILLING, ARMED) and the PAT_W legality bounds (min 2, max 16).
REQ-032 The saturating match counter shall be a sub-module named sat_counter (parameter CNT_W; ports clk, rst, inc, clr, count).
REQ-033 The top level shall contain the window shift register, the fill counter and the FSM.

Verification
REQ-034 Default parameters, rst for 2 cycles, then valid bits 0,1,0,1 -> Y=1 exactly one cycle after the 4th bit; match_count=1; armed=1 from the cycle after the 4th bit.
REQ-035 OVERLAP=1, valid bits 0,1,0,1,0,1 -> two Y pulses, after bits 4 and 6; match_count=2. OVERLAP=0, same stream -> one pulse, after bit 4; match_count=1.
REQ-036 Bits 0,1 valid, then A_valid=0 for 3 cycles with A toggling, then bits 0,1 valid -> a single Y pulse after the final bit; the bits presented while A_valid=0 have no effect.
REQ-037 CNT_W=2, 5 overlapping matches -> match_count reads 1,2,3,3,3. clr_cnt asserted on the 5th match cycle -> match_count=0 and Y=1 on that edge.
REQ-038 rst asserted after bits 0,1,0, then bit 1 supplied -> no Y pulse, armed=0, fill=1. Build without SEQ_DETECTOR_COUNT_EN, repeat REQ-034 -> Y behaviour identical and match_count=0 throughout.
